// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request per cycle to a
// fixed one-cycle-latency instruction memory, predecodes each returned word
// with a static predictor, and buffers {instruction, pc, prediction} in a
// small FIFO that feeds decode.
//
// Decode handshake: o_id_valid/o_id_* describe the FIFO head; the head is
// consumed on a cycle where o_id_valid && i_id_ready. While o_id_valid is
// high and i_id_ready is low, every o_id_* output holds its value. A redirect
// overrides the handshake: the head offered in that cycle is discarded.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_id_ready,
    output logic        o_id_valid,
    output logic [31:0] o_id_instruction,
    output logic [31:0] o_id_pc,
    output logic        o_id_pred_taken,
    output logic [31:0] o_id_pred_target
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    // PC and in-flight request tracking
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    // Output buffer
    logic [31:0]      r_fifo_instr  [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc     [FIFO_DEPTH];
    logic             r_fifo_taken  [FIFO_DEPTH];
    logic [31:0]      r_fifo_target [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Predecode and control
    logic [6:0]  w_opcode;
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic        w_is_jal;
    logic        w_is_bback;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;
    logic [31:0] w_target_aligned;
    logic        w_resp_taken;
    logic [31:0] w_addr;
    logic        w_pop;
    logic        w_fifo_pop;
    logic        w_push;
    logic [CNT_W:0] w_pending;
    logic        w_issue;
    logic        w_unused;

    // Low redirect bits are architecturally ignored.
    assign w_unused = ^i_redirect_pc[1:0];

    assign w_opcode = i_imem_rdata[6:0];
    assign w_j_imm  = {{11{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[19:12],
                       i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
    assign w_b_imm  = {{19{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[7],
                       i_imem_rdata[30:25], i_imem_rdata[11:8], 1'b0};
    assign w_is_jal   = (w_opcode == 7'b1101111);
    assign w_is_bback = (w_opcode == 7'b1100011) && i_imem_rdata[31];

    // Static prediction on the word returning this cycle: JAL and backward branches taken.
    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_target = r_inflight_pc + 32'd4;
        if (PREDICT_EN) begin
            if (w_is_jal) begin
                w_pred_taken  = 1'b1;
                w_pred_target = r_inflight_pc + w_j_imm;
            end else if (w_is_bback) begin
                w_pred_taken  = 1'b1;
                w_pred_target = r_inflight_pc + w_b_imm;
            end
        end
    end

    // A taken response steers this cycle's request straight to the target.
    assign w_target_aligned = {w_pred_target[31:2], 2'b00};
    assign w_resp_taken     = r_inflight && w_pred_taken;
    assign w_addr           = w_resp_taken ? w_target_aligned : r_fetch_pc;

    // Issue only if the word could still find a FIFO slot when it returns.
    assign w_pop      = o_id_valid && i_id_ready;
    assign w_fifo_pop = w_pop && !i_redirect_valid;
    assign w_push     = r_inflight && !i_redirect_valid;
    assign w_pending  = {1'b0, r_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
    assign w_issue    = !i_rst && !i_redirect_valid && (w_pending < DEPTH_EXT);

    assign o_imem_req  = w_issue;
    assign o_imem_addr = i_rst ? 32'd0 : w_addr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // PC update: reset, then redirect, then sequential/predicted flow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
        end else if (i_redirect_valid) begin
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= w_addr;
                r_fetch_pc    <= w_addr + 32'd4;
            end else if (w_resp_taken) begin
                r_fetch_pc <= w_target_aligned;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_fifo_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture the returning word with its PC and prediction.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_fifo_instr[r_wr_ptr]  <= i_imem_rdata;
            r_fifo_pc[r_wr_ptr]     <= r_inflight_pc;
            r_fifo_taken[r_wr_ptr]  <= w_pred_taken;
            r_fifo_target[r_wr_ptr] <= w_pred_target;
        end
    end

    // Head presentation; fields read as zero whenever no entry is offered.
    always_comb begin
        o_id_valid       = !i_rst && (r_count != '0);
        o_id_instruction = 32'd0;
        o_id_pc          = 32'd0;
        o_id_pred_taken  = 1'b0;
        o_id_pred_target = 32'd0;
        if (o_id_valid) begin
            o_id_instruction = r_fifo_instr[r_rd_ptr];
            o_id_pc          = r_fifo_pc[r_rd_ptr];
            o_id_pred_taken  = r_fifo_taken[r_rd_ptr];
            o_id_pred_target = r_fifo_target[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by randomized traffic,
// all checked against a program-flow reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        i_id_ready;
    logic        o_id_valid;
    logic [31:0] o_id_instruction;
    logic [31:0] o_id_pc;
    logic        o_id_pred_taken;
    logic [31:0] o_id_pred_target;

    if_fetch_stage #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH),
        .PREDICT_EN (1'b1)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rdata     (i_imem_rdata),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_id_ready       (i_id_ready),
        .o_id_valid       (o_id_valid),
        .o_id_instruction (o_id_instruction),
        .o_id_pc          (o_id_pc),
        .o_id_pred_taken  (o_id_pred_taken),
        .o_id_pred_target (o_id_pred_target)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [31:0] cyc;
    } ent_t;

    // Scoreboard: every fetched-but-not-consumed instruction, oldest first.
    ent_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    bit          random_mode;
    logic [31:0] m_next_addr;
    int          cyc;
    int          n_checks;
    int          n_pass;
    int          n_fail;

    logic        obs_req, obs_valid, obs_taken;
    logic [31:0] obs_addr, obs_pc, obs_instr, obs_target;
    logic        pend_req;
    logic [31:0] pend_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_word();
        logic [20:0] j;
        logic [12:0] b;
        logic [31:0] w;
        w = NOP;
        case ($urandom_range(0, 5))
            0, 1: w = NOP;
            2: begin
                j = 21'($urandom) & ~21'd1;
                w = {j[20], j[10:1], j[11], j[19:12], 5'($urandom), 7'b1101111};
            end
            3: begin
                b = {1'b1, 12'($urandom)} & ~13'd1;
                w = {b[12], b[10:5], 10'($urandom), 3'($urandom), b[4:1], b[11], 7'b1100011};
            end
            4: begin
                b = {1'b0, 12'($urandom)} & ~13'd1;
                w = {b[12], b[10:5], 10'($urandom), 3'($urandom), b[4:1], b[11], 7'b1100011};
            end
            default: w = $urandom;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (!random_mode) return NOP;
        mem[a] = gen_word();
        return mem[a];
    endfunction

    // Static prediction computed from the immediate's numeric value.
    function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                    output logic taken, output logic [31:0] target);
        int imm;
        taken  = 1'b0;
        target = pc + 32'd4;
        if (w[6:0] == 7'h6F) begin
            imm = w[31] ? -(1 << 20) : 0;
            imm += int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            taken  = 1'b1;
            target = pc + imm;
        end else if (w[6:0] == 7'h63 && w[31]) begin
            imm = -4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            taken  = 1'b1;
            target = pc + imm;
        end
    endfunction

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model and memory.
    task automatic tick(input logic rst_v, input logic rdr_v, input logic [31:0] rdr_pc,
                        input logic rdy_v);
        logic        exp_valid, exp_req, pop, taken;
        logic [31:0] target, w;
        int          outstanding;
        ent_t        e;
        i_rst = rst_v;
        i_redirect_valid = rdr_v;
        i_redirect_pc = rdr_pc;
        i_id_ready = rdy_v;
        @(negedge i_clk);
        obs_req = o_imem_req;
        obs_addr = o_imem_addr;
        obs_valid = o_id_valid;
        obs_pc = o_id_pc;
        obs_instr = o_id_instruction;
        obs_taken = o_id_pred_taken;
        obs_target = o_id_pred_target;

        exp_valid = 1'b0;
        if (!rst_v && exp_q.size() > 0) exp_valid = (exp_q[0].cyc + 2 <= 32'(cyc));
        chk("id_valid", 32'(obs_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("id_pc", obs_pc, exp_q[0].pc);
            chk("id_instruction", obs_instr, exp_q[0].instr);
            chk("id_pred_taken", 32'(obs_taken), 32'(exp_q[0].taken));
            chk("id_pred_target", obs_target, exp_q[0].target);
        end
        if (rst_v) begin
            chk("rst_id_pc", obs_pc, 32'd0);
            chk("rst_id_instruction", obs_instr, 32'd0);
            chk("rst_id_pred_target", obs_target, 32'd0);
            chk("rst_imem_addr", obs_addr, 32'd0);
        end
        outstanding = exp_q.size();
        exp_req = !rst_v && !rdr_v &&
                  ((outstanding - ((exp_valid && rdy_v) ? 1 : 0)) < DEPTH);
        chk("imem_req", 32'(obs_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", obs_addr, m_next_addr);

        pop = exp_valid && rdy_v && !rdr_v;
        if (pop) void'(exp_q.pop_front());
        if (rst_v) begin
            exp_q.delete();
            m_next_addr = RESET_PC;
        end else if (rdr_v) begin
            exp_q.delete();
            m_next_addr = {rdr_pc[31:2], 2'b00};
        end else if (exp_req) begin
            w = mem_word(m_next_addr);
            predict(m_next_addr, w, taken, target);
            e.instr = w;
            e.pc = m_next_addr;
            e.taken = taken;
            e.target = target;
            e.cyc = 32'(cyc);
            exp_q.push_back(e);
            m_next_addr = taken ? {target[31:2], 2'b00} : m_next_addr + 32'd4;
        end

        // Memory: answer exactly one cycle after a request, junk otherwise.
        pend_req = obs_req;
        pend_addr = obs_addr;
        @(posedge i_clk);
        #1;
        i_imem_rdata = pend_req ? mem_word(pend_addr) : $urandom;
        cyc++;
    endtask

    initial begin
        logic        r_v, d_v, y_v;
        logic [31:0] d_pc;
        int          rdy_pct;
        n_checks = 0;
        n_pass = 0;
        n_fail = 0;
        cyc = 0;
        random_mode = 1'b0;
        m_next_addr = RESET_PC;
        i_rst = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc = 32'd0;
        i_id_ready = 1'b1;
        i_imem_rdata = 32'd0;
        mem[32'h20]  = 32'h1000_006F;  // jal x0, +0x100
        mem[32'h120] = 32'h0000_0463;  // beq x0, x0, +8
        mem[32'h40]  = 32'hFE00_0EE3;  // beq x0, x0, -4

        repeat (3) tick(1'b1, 1'b0, 32'd0, 1'b1);

        // Streaming from reset
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s1_first_req", 32'(obs_req), 32'd1);
        chk("s1_first_addr", obs_addr, 32'h0);
        chk("s1_valid_c0", 32'(obs_valid), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s1_addr_c1", obs_addr, 32'h4);
        chk("s1_valid_c1", 32'(obs_valid), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s1_valid_c2", 32'(obs_valid), 32'd1);
        chk("s1_pc_c2", obs_pc, 32'h0);
        chk("s1_addr_c2", obs_addr, 32'h8);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s1_pc_c3", obs_pc, 32'h4);
        repeat (2) tick(1'b0, 1'b0, 32'd0, 1'b1);

        // Decode stall at 0x10
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'd0, 1'b0);
            chk("s2_stall_valid", 32'(obs_valid), 32'd1);
            chk("s2_stall_pc", obs_pc, 32'h10);
            chk("s2_stall_req", 32'(obs_req), 32'd0);
        end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s2_rel_pc0", obs_pc, 32'h10);
        chk("s2_rel_addr", obs_addr, 32'h18);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s2_rel_pc1", obs_pc, 32'h14);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s2_rel_pc2", obs_pc, 32'h18);
        chk("s4_addr_jal", obs_addr, 32'h20);

        // JAL at 0x20 redirects the next request in the response cycle
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s4_req_target", 32'(obs_req), 32'd1);
        chk("s4_addr_target", obs_addr, 32'h120);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s4_jal_pc", obs_pc, 32'h20);
        chk("s4_jal_taken", 32'(obs_taken), 32'd1);
        chk("s4_jal_target", obs_target, 32'h120);
        chk("s4_jal_instr", obs_instr, 32'h1000_006F);
        chk("s4_fwd_addr", obs_addr, 32'h124);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s4_fwd_pc", obs_pc, 32'h120);
        chk("s4_fwd_taken", 32'(obs_taken), 32'd0);
        chk("s4_fwd_target", obs_target, 32'h124);

        // Backward branch loop at 0x40
        tick(1'b0, 1'b1, 32'h40, 1'b1);
        chk("s3_redir_req", 32'(obs_req), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s3_addr_40", obs_addr, 32'h40);
        chk("s3_valid_empty", 32'(obs_valid), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s3_addr_3c", obs_addr, 32'h3C);
        chk("s3_req_3c", 32'(obs_req), 32'd1);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s3_br_pc", obs_pc, 32'h40);
        chk("s3_br_taken", 32'(obs_taken), 32'd1);
        chk("s3_br_target", obs_target, 32'h3C);
        chk("s3_br_instr", obs_instr, 32'hFE00_0EE3);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s3_nop_pc", obs_pc, 32'h3C);
        chk("s3_nop_target", obs_target, 32'h40);

        // Redirect with buffer and memory both occupied
        tick(1'b0, 1'b1, 32'h800, 1'b0);
        chk("s5_valid_before", 32'(obs_valid), 32'd1);
        chk("s5_req_redirect", 32'(obs_req), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s5_flushed", 32'(obs_valid), 32'd0);
        chk("s5_addr", obs_addr, 32'h800);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s5_no_stale", 32'(obs_valid), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s5_pc", obs_pc, 32'h800);
        repeat (2) tick(1'b0, 1'b0, 32'd0, 1'b1);

        // Reset mid-stream
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        chk("s6_valid_rst", 32'(obs_valid), 32'd0);
        chk("s6_req_rst", 32'(obs_req), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s6_valid_after", 32'(obs_valid), 32'd0);
        chk("s6_restart_addr", obs_addr, RESET_PC);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s6_addr4", obs_addr, RESET_PC + 32'd4);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("s6_pc0", obs_pc, RESET_PC);

        // Randomized traffic over a freshly generated program
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        mem.delete();
        random_mode = 1'b1;
        rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) rdy_pct = $urandom_range(20, 100);
            r_v = ($urandom_range(0, 199) == 0);
            d_v = !r_v && ($urandom_range(0, 29) == 0);
            d_pc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFF);
            y_v = ($urandom_range(1, 100) <= rdy_pct);
            tick(r_v, d_v, d_pc, y_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
